// File: rtl/ss_key_ctrl_if.sv
// Pad sampling, frame strobe and command handshake between the hotkey
// sequencer (master) and the mapper's vblank hook (slave).
interface ss_key_ctrl_if;
   logic       pad_vld;
   logic [7:0] pad_dat;
   logic       vblank;
   logic       ss_ack;
   logic       ss_req;
   logic [1:0] ss_cmd;
   logic       busy;
   logic       tmo_err;

   modport master (
      input  pad_vld,
      input  pad_dat,
      input  vblank,
      input  ss_ack,
      output ss_req,
      output ss_cmd,
      output busy,
      output tmo_err
   );

   modport slave (
      output pad_vld,
      output pad_dat,
      output vblank,
      output ss_ack,
      input  ss_req,
      input  ss_cmd,
      input  busy,
      input  tmo_err
   );
endinterface

// File: rtl/ss_key_ctrl.sv
// Save-state / menu hotkey sequencer: matches held pad combos or a debounced
// external button and issues one command request to the in-game menu hook.
module ss_key_ctrl #(
   parameter int unsigned HOLD_FRAMES = 3,
   parameter logic [15:0] DEB_CYC     = 16'd50000,
   parameter logic [7:0]  ACK_TMO     = 8'd60
) (
   input  logic       clk,
   input  logic       map_rst_n,
   input  logic       ss_on,
   input  logic       ss_btn,
   input  logic [7:0] key_save,
   input  logic [7:0] key_load,
   input  logic [7:0] key_menu,
   input  logic       ext_btn,
   ss_key_ctrl_if.master hk
);

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_SAVE = 2'd1,
      CMD_LOAD = 2'd2,
      CMD_MENU = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_REQ     = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   localparam logic [3:0]  HOLD_LIM = 4'(HOLD_FRAMES);
   localparam logic [15:0] DEB_LAST = DEB_CYC - 16'd1;

   state_e      state_q, state_d;
   cmd_e        arm_cmd_q, arm_cmd_d;
   cmd_e        cmd_q, cmd_d;
   cmd_e        ss_cmd_q, ss_cmd_d;
   cmd_e        cand;
   logic [3:0]  hold_cnt_q, hold_cnt_d, hold_inc;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d, tmo_inc;
   logic        ss_req_q, ss_req_d;
   logic        tmo_err_q, tmo_err_d;
   logic [7:0]  pad_lat_q, pad_lat_d;
   logic [2:0]  sync_q, sync_d;
   logic [15:0] deb_cnt_q, deb_cnt_d;
   logic        deb_lvl_q, deb_lvl_d;
   logic        btn_rise;
   logic        btn_go;

   always_comb begin
      pad_lat_d = pad_lat_q;
      if (hk.pad_vld) begin
         pad_lat_d = hk.pad_dat;
      end
   end

   always_comb begin
      cand = CMD_NONE;
      if (key_menu != 8'd0 && pad_lat_q == key_menu) begin
         cand = CMD_MENU;
      end else if (key_load != 8'd0 && pad_lat_q == key_load) begin
         cand = CMD_LOAD;
      end else if (key_save != 8'd0 && pad_lat_q == key_save) begin
         cand = CMD_SAVE;
      end
   end

   // sync_q[1] is the synchronized level, sync_q[2] its previous value for change detection
   always_comb begin
      sync_d    = {sync_q[1:0], ext_btn};
      deb_cnt_d = deb_cnt_q;
      deb_lvl_d = deb_lvl_q;
      if (sync_q[1] != sync_q[2]) begin
         deb_cnt_d = 16'd0;
      end else if (deb_cnt_q == DEB_LAST) begin
         deb_lvl_d = sync_q[1];
      end else begin
         deb_cnt_d = deb_cnt_q + 16'd1;
      end
   end

   assign btn_rise = deb_lvl_d & ~deb_lvl_q;
   assign btn_go   = btn_rise & ss_btn;
   assign hold_inc = (hold_cnt_q == 4'hF) ? hold_cnt_q : hold_cnt_q + 4'd1;
   assign tmo_inc  = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      arm_cmd_d  = arm_cmd_q;
      cmd_d      = cmd_q;
      hold_cnt_d = hold_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      tmo_err_d  = 1'b0;

      if (!ss_on) begin
         state_d    = ST_IDLE;
         arm_cmd_d  = CMD_NONE;
         cmd_d      = CMD_NONE;
         hold_cnt_d = 4'd0;
         tmo_cnt_d  = 8'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cmd_d      = CMD_NONE;
               hold_cnt_d = 4'd0;
               tmo_cnt_d  = 8'd0;
               if (btn_go) begin
                  state_d = ST_REQ;
                  cmd_d   = CMD_MENU;
               end else if (hk.vblank && cand != CMD_NONE) begin
                  if (HOLD_LIM <= 4'd1) begin
                     state_d = ST_REQ;
                     cmd_d   = cand;
                  end else begin
                     state_d    = ST_ARM;
                     hold_cnt_d = 4'd1;
                     arm_cmd_d  = cand;
                  end
               end
            end
            ST_ARM: begin
               if (btn_go) begin
                  state_d    = ST_REQ;
                  cmd_d      = CMD_MENU;
                  hold_cnt_d = 4'd0;
               end else if (hk.vblank) begin
                  if (cand == arm_cmd_q) begin
                     hold_cnt_d = hold_inc;
                     if (hold_inc >= HOLD_LIM) begin
                        state_d    = ST_REQ;
                        cmd_d      = arm_cmd_q;
                        hold_cnt_d = 4'd0;
                     end
                  end else begin
                     state_d    = ST_IDLE;
                     hold_cnt_d = 4'd0;
                  end
               end
            end
            // An acknowledge in the same cycle as the deciding vblank beats the timeout
            ST_REQ: begin
               if (hk.ss_ack) begin
                  state_d   = ST_RELEASE;
                  tmo_cnt_d = 8'd0;
               end else if (hk.vblank) begin
                  tmo_cnt_d = tmo_inc;
                  if (ACK_TMO != 8'd0 && tmo_inc == ACK_TMO) begin
                     state_d   = ST_RELEASE;
                     tmo_err_d = 1'b1;
                     tmo_cnt_d = 8'd0;
                  end
               end
            end
            ST_RELEASE: begin
               cmd_d = CMD_NONE;
               if (hk.vblank && pad_lat_q == 8'd0 && !deb_lvl_q) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      ss_req_d = (state_d == ST_REQ);
      ss_cmd_d = (state_d == ST_REQ) ? cmd_d : CMD_NONE;
   end

   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n) begin
         state_q    <= ST_IDLE;
         arm_cmd_q  <= CMD_NONE;
         cmd_q      <= CMD_NONE;
         ss_cmd_q   <= CMD_NONE;
         hold_cnt_q <= 4'd0;
         tmo_cnt_q  <= 8'd0;
         ss_req_q   <= 1'b0;
         tmo_err_q  <= 1'b0;
         pad_lat_q  <= 8'd0;
         sync_q     <= 3'd0;
         deb_cnt_q  <= 16'd0;
         deb_lvl_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         arm_cmd_q  <= arm_cmd_d;
         cmd_q      <= cmd_d;
         ss_cmd_q   <= ss_cmd_d;
         hold_cnt_q <= hold_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         ss_req_q   <= ss_req_d;
         tmo_err_q  <= tmo_err_d;
         pad_lat_q  <= pad_lat_d;
         sync_q     <= sync_d;
         deb_cnt_q  <= deb_cnt_d;
         deb_lvl_q  <= deb_lvl_d;
      end
   end

   assign hk.ss_req  = ss_req_q;
   assign hk.ss_cmd  = ss_cmd_q;
   assign hk.tmo_err = tmo_err_q;
   assign hk.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ss_key_ctrl.sv
// Testbench for ss_key_ctrl: directed scenarios for each feature followed by
// randomized pad traffic checked against a frame-level model of the hotkey rules.
module tb_ss_key_ctrl;

   localparam int          HOLD = 3;
   localparam logic [15:0] DEB  = 16'd1000;
   localparam logic [7:0]  TMO  = 8'd4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ss_on = 1'b0;
   logic       ss_btn = 1'b0;
   logic [7:0] key_save = 8'd0;
   logic [7:0] key_load = 8'd0;
   logic [7:0] key_menu = 8'd0;
   logic       ext_btn = 1'b0;

   int tests = 0;
   int fails = 0;
   int tmo_pulses = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;

   ss_key_ctrl_if bus ();

   ss_key_ctrl #(
      .HOLD_FRAMES(HOLD),
      .DEB_CYC    (DEB),
      .ACK_TMO    (TMO)
   ) dut (
      .clk      (clk),
      .map_rst_n(rst_n),
      .ss_on    (ss_on),
      .ss_btn   (ss_btn),
      .key_save (key_save),
      .key_load (key_load),
      .key_menu (key_menu),
      .ext_btn  (ext_btn),
      .hk       (bus.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.tmo_err === 1'b1) tmo_pulses++;
      if (bus.ss_req === 1'b1 && req_prev !== 1'b1) req_rises++;
      req_prev = bus.ss_req;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic set_pad(input logic [7:0] v);
      bus.pad_dat = v;
      bus.pad_vld = 1'b1;
      tick();
      bus.pad_vld = 1'b0;
   endtask

   task automatic pulse_vblank();
      bus.vblank = 1'b1;
      tick();
      bus.vblank = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.ss_ack = 1'b1;
      tick();
      bus.ss_ack = 1'b0;
   endtask

   task automatic wait_req(input int max_cyc, output int waited);
      waited = 0;
      while (bus.ss_req !== 1'b1 && waited < max_cyc) begin
         tick();
         waited++;
      end
   endtask

   function automatic logic [1:0] model_cand(input logic [7:0] p, input logic [7:0] s,
                                             input logic [7:0] l, input logic [7:0] m);
      if (m != 8'd0 && p == m) return 2'd3;
      if (l != 8'd0 && p == l) return 2'd2;
      if (s != 8'd0 && p == s) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [7:0] pick_key(input logic [7:0] shared);
      int r;
      r = $urandom % 6;
      if (r == 0) return 8'd0;
      if (r == 1) return shared;
      return 8'($urandom);
   endfunction

   task automatic test_reset();
      bus.pad_vld = 1'b0;
      bus.pad_dat = 8'd0;
      bus.vblank  = 1'b0;
      bus.ss_ack  = 1'b0;
      rst_n = 1'b0;
      cycles(3);
      rst_n = 1'b1;
      tick();
      tests++; if (bus.ss_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b want 0", bus.ss_req); end
      tests++; if (bus.ss_cmd !== 2'd0) begin fails++; $display("[TB] FAIL reset_cmd: got %0d want 0", bus.ss_cmd); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
      tests++; if (bus.tmo_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_tmo: got %b want 0", bus.tmo_err); end
   endtask

   task automatic test_save_ack();
      int w;
      ss_on = 1'b1;
      key_save = 8'h81; key_load = 8'h00; key_menu = 8'h00;
      set_pad(8'h81);
      for (int i = 0; i < 2; i++) begin
         pulse_vblank();
         tests++; if (bus.ss_req !== 1'b0) begin fails++; $display("[TB] FAIL save_early_req: frame %0d got %b want 0", i, bus.ss_req); end
         tests++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL save_arm_busy: frame %0d got %b want 1", i, bus.busy); end
      end
      pulse_vblank();
      wait_req(3, w);
      tests++; if (bus.ss_req !== 1'b1) begin fails++; $display("[TB] FAIL save_req: got %b want 1", bus.ss_req); end
      tests++; if (bus.ss_cmd !== 2'd1) begin fails++; $display("[TB] FAIL save_cmd: got %0d want 1", bus.ss_cmd); end
      pulse_ack();
      tests++; if (bus.ss_req !== 1'b0) begin fails++; $display("[TB] FAIL save_ack_req: got %b want 0", bus.ss_req); end
      tests++; if (bus.ss_cmd !== 2'd0) begin fails++; $display("[TB] FAIL save_ack_cmd: got %0d want 0", bus.ss_cmd); end
      pulse_vblank();
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL save_hold_release: busy got %b want 1", bus.busy); end
      set_pad(8'h00);
      pulse_vblank();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL save_idle: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_priority_abort();
      int r0, w;
      key_save = 8'h00; key_load = 8'h40; key_menu = 8'h40;
      r0 = req_rises;
      set_pad(8'h40);
      pulse_vblank();
      pulse_vblank();
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL prio_armed: busy got %b want 1", bus.busy); end
      set_pad(8'h41);
      pulse_vblank();
      cycles(2);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL prio_abort_busy: got %b want 0", bus.busy); end
      tests++; if (req_rises !== r0) begin fails++; $display("[TB] FAIL prio_abort_req: rises got %0d want %0d", req_rises, r0); end
      set_pad(8'h40);
      repeat (HOLD) pulse_vblank();
      wait_req(3, w);
      tests++; if (bus.ss_req !== 1'b1) begin fails++; $display("[TB] FAIL prio_req: got %b want 1", bus.ss_req); end
      tests++; if (bus.ss_cmd !== 2'd3) begin fails++; $display("[TB] FAIL prio_cmd: got %0d want 3", bus.ss_cmd); end
      pulse_ack();
      set_pad(8'h00);
      pulse_vblank();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL prio_idle: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_button_debounce();
      int r0, w;
      key_save = 8'h00; key_load = 8'h00; key_menu = 8'h00;
      ss_btn = 1'b1;
      ext_btn = 1'b0;
      r0 = req_rises;
      for (int i = 0; i < 20; i++) begin
         ext_btn = ~ext_btn;
         cycles(100);
      end
      tests++; if (req_rises !== r0) begin fails++; $display("[TB] FAIL btn_bounce: rises got %0d want %0d", req_rises, r0); end
      ext_btn = 1'b1;
      wait_req(int'(DEB) + 50, w);
      tests++; if (bus.ss_req !== 1'b1) begin fails++; $display("[TB] FAIL btn_req: got %b want 1 after %0d cycles", bus.ss_req, w); end
      tests++; if (w < int'(DEB) || w > int'(DEB) + 10) begin fails++; $display("[TB] FAIL btn_latency: got %0d cycles want %0d..%0d", w, DEB, int'(DEB) + 10); end
      tests++; if (bus.ss_cmd !== 2'd3) begin fails++; $display("[TB] FAIL btn_cmd: got %0d want 3", bus.ss_cmd); end
      pulse_ack();
      ext_btn = 1'b0;
      pulse_vblank();
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL btn_release_held: busy got %b want 1", bus.busy); end
      cycles(int'(DEB) + 20);
      pulse_vblank();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL btn_idle: busy got %b want 0", bus.busy); end
      tests++; if (req_rises !== r0 + 1) begin fails++; $display("[TB] FAIL btn_once: rises got %0d want %0d", req_rises, r0 + 1); end
      ss_btn = 1'b0;
   endtask

   task automatic test_timeout();
      int p0, r0, w;
      key_save = 8'h00; key_load = 8'h22; key_menu = 8'h00;
      set_pad(8'h22);
      repeat (HOLD) pulse_vblank();
      wait_req(3, w);
      tests++; if (bus.ss_cmd !== 2'd2) begin fails++; $display("[TB] FAIL tmo_cmd: got %0d want 2", bus.ss_cmd); end
      p0 = tmo_pulses;
      repeat (int'(TMO) - 1) pulse_vblank();
      cycles(2);
      tests++; if (tmo_pulses !== p0) begin fails++; $display("[TB] FAIL tmo_early: pulses got %0d want %0d", tmo_pulses, p0); end
      tests++; if (bus.ss_req !== 1'b1) begin fails++; $display("[TB] FAIL tmo_wait_req: got %b want 1", bus.ss_req); end
      pulse_vblank();
      cycles(2);
      tests++; if (tmo_pulses !== p0 + 1) begin fails++; $display("[TB] FAIL tmo_pulse: pulses got %0d want %0d", tmo_pulses, p0 + 1); end
      tests++; if (bus.ss_req !== 1'b0) begin fails++; $display("[TB] FAIL tmo_drop_req: got %b want 0", bus.ss_req); end
      r0 = req_rises;
      repeat (4) pulse_vblank();
      tests++; if (req_rises !== r0) begin fails++; $display("[TB] FAIL tmo_no_retrigger: rises got %0d want %0d", req_rises, r0); end
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL tmo_release_busy: got %b want 1", bus.busy); end
      set_pad(8'h00);
      pulse_vblank();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL tmo_idle: busy got %b want 0", bus.busy); end
      set_pad(8'h22);
      repeat (HOLD) pulse_vblank();
      wait_req(3, w);
      p0 = tmo_pulses;
      repeat (int'(TMO) - 1) pulse_vblank();
      bus.ss_ack = 1'b1;
      bus.vblank = 1'b1;
      tick();
      bus.ss_ack = 1'b0;
      bus.vblank = 1'b0;
      cycles(2);
      tests++; if (tmo_pulses !== p0) begin fails++; $display("[TB] FAIL ack_beats_tmo: pulses got %0d want %0d", tmo_pulses, p0); end
      tests++; if (bus.ss_req !== 1'b0) begin fails++; $display("[TB] FAIL ack_beats_tmo_req: got %b want 0", bus.ss_req); end
      set_pad(8'h00);
      pulse_vblank();
   endtask

   task automatic test_ss_on_and_reset();
      int w;
      key_save = 8'h00; key_load = 8'h00; key_menu = 8'h10;
      set_pad(8'h10);
      repeat (HOLD) pulse_vblank();
      wait_req(3, w);
      ss_on = 1'b0;
      tick();
      tests++; if (bus.ss_req !== 1'b0) begin fails++; $display("[TB] FAIL sson_req: got %b want 0", bus.ss_req); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL sson_busy: got %b want 0", bus.busy); end
      ss_on = 1'b1;
      pulse_vblank();
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL rst_armed: busy got %b want 1", bus.busy); end
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_async_busy: got %b want 0", bus.busy); end
      tests++; if (bus.ss_req !== 1'b0 || bus.ss_cmd !== 2'd0 || bus.tmo_err !== 1'b0) begin
         fails++; $display("[TB] FAIL rst_async_out: req %b cmd %0d tmo %b want all 0", bus.ss_req, bus.ss_cmd, bus.tmo_err);
      end
      tick();
      rst_n = 1'b1;
      tick();
      pulse_vblank();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_pad_cleared: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_zero_keys();
      int r0;
      key_save = 8'h00; key_load = 8'h00; key_menu = 8'h00;
      r0 = req_rises;
      set_pad(8'h00);
      repeat (5) pulse_vblank();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL zero_busy: got %b want 0", bus.busy); end
      pulse_ack();
      cycles(2);
      tests++; if (bus.busy !== 1'b0 || req_rises !== r0) begin
         fails++; $display("[TB] FAIL zero_stray_ack: busy %b rises %0d want 0 and %0d", bus.busy, req_rises, r0);
      end
   endtask

   task automatic test_random();
      logic [7:0] ks, kl, km, sh, p;
      logic [1:0] c, arm;
      int streak;
      bit rel, exp_req;
      set_pad(8'h00);
      pulse_vblank();
      streak = 0; rel = 1'b0; arm = 2'd0; p = 8'h00;
      for (int e = 0; e < 8; e++) begin
         sh = 8'($urandom_range(1, 255));
         ks = pick_key(sh); kl = pick_key(sh); km = pick_key(sh);
         key_save = ks; key_load = kl; key_menu = km;
         for (int f = 0; f < 30; f++) begin
            case ($urandom % 8)
               0, 1, 2: p = p;
               3:       p = ks;
               4:       p = kl;
               5:       p = km;
               6:       p = 8'h00;
               default: p = 8'($urandom);
            endcase
            set_pad(p);
            pulse_vblank();
            c = model_cand(p, ks, kl, km);
            exp_req = 1'b0;
            if (rel) begin
               if (p == 8'h00) rel = 1'b0;
            end else if (streak > 0) begin
               if (c == arm) begin
                  streak++;
                  if (streak >= HOLD) begin
                     exp_req = 1'b1;
                     streak = 0;
                  end
               end else begin
                  streak = 0;
               end
            end else if (c != 2'd0) begin
               streak = 1;
               arm = c;
            end
            tests++; if (bus.ss_req !== exp_req) begin fails++; $display("[TB] FAIL rnd_req: e%0d f%0d pad %h got %b want %b", e, f, p, bus.ss_req, exp_req); end
            tests++; if (bus.busy !== (rel || streak > 0 || exp_req)) begin
               fails++; $display("[TB] FAIL rnd_busy: e%0d f%0d pad %h got %b want %b", e, f, p, bus.busy, (rel || streak > 0 || exp_req));
            end
            if (exp_req) begin
               tests++; if (bus.ss_cmd !== arm) begin fails++; $display("[TB] FAIL rnd_cmd: e%0d f%0d got %0d want %0d", e, f, bus.ss_cmd, arm); end
               cycles($urandom_range(0, 3));
               pulse_ack();
               tests++; if (bus.ss_req !== 1'b0) begin fails++; $display("[TB] FAIL rnd_ack: e%0d f%0d got %b want 0", e, f, bus.ss_req); end
               rel = 1'b1;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_save_ack();
      test_priority_abort();
      test_button_debounce();
      test_timeout();
      test_ss_on_and_reset();
      test_zero_keys();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
